// File: rtl/gray_code_pkg.sv
// Shared constants and chunking helpers for the pipelined Gray/binary converter.
package gray_code_pkg;

  localparam logic MODE_B2G = 1'b0;
  localparam logic MODE_G2B = 1'b1;

  function automatic int chunk_size(int width, int stages);
    return (width + stages - 1) / stages;
  endfunction

  // Highest bit resolved by a stage; negative when the stage has no chunk.
  function automatic int chunk_hi(int stage, int width, int stages);
    return width - 1 - stage * chunk_size(width, stages);
  endfunction

  function automatic int chunk_lo(int stage, int width, int stages);
    int lo;
    lo = width - (stage + 1) * chunk_size(width, stages);
    return (lo < 0) ? 0 : lo;
  endfunction

endpackage

// File: rtl/gray_pipe_stage.sv
// One register slice of the converter: resolves its MSB-first chunk of a Gray->binary word,
// or performs the whole binary->Gray step when it is the first stage.
module gray_pipe_stage
  import gray_code_pkg::*;
#(
  parameter int unsigned STAGE  = 0,
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             up_valid,
  input  logic             up_mode,
  input  logic [WIDTH-1:0] up_data,
  input  logic             up_parity,
  output logic             valid,
  output logic             mode,
  output logic [WIDTH-1:0] data,
  output logic             parity
);

  localparam int Hi = chunk_hi(int'(STAGE), int'(WIDTH), int'(STAGES));
  localparam int Lo = chunk_lo(int'(STAGE), int'(WIDTH), int'(STAGES));

  logic             valid_q, mode_q, parity_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic             parity_d;

  always_comb begin
    data_d   = up_data;
    parity_d = up_parity;
    if (up_mode == MODE_G2B) begin
      // parity_d is the binary value of the bit just resolved, carried to the next chunk
      for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
        if (i <= Hi && i >= Lo) begin
          parity_d  = parity_d ^ up_data[i];
          data_d[i] = parity_d;
        end
      end
    end else if (STAGE == 0) begin
      data_d = up_data ^ (up_data >> 1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      mode_q   <= MODE_B2G;
      data_q   <= '0;
      parity_q <= 1'b0;
    end else if (load) begin
      valid_q <= up_valid;
      if (up_valid) begin
        mode_q   <= up_mode;
        data_q   <= data_d;
        parity_q <= parity_d;
      end
    end
  end

  assign valid  = valid_q;
  assign mode   = mode_q;
  assign data   = data_q;
  assign parity = parity_q;

endmodule

// File: rtl/gray_code_pipe.sv
// Pipelined bidirectional Gray/binary converter with valid/ready on both sides.
// Holds only the ready chain and the wiring of STAGES register slices.
module gray_code_pipe
  import gray_code_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_mode
);

  logic [STAGES-1:0] stage_valid;
  logic [STAGES-1:0] stage_mode;
  logic [STAGES-1:0] stage_parity;
  logic [STAGES-1:0] stage_load;
  logic [WIDTH-1:0]  stage_data [STAGES];

  // A stage may load when it is empty or everything downstream of it can move.
  always_comb begin
    logic chain;
    stage_load = '0;
    chain      = out_ready;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      chain         = chain | ~stage_valid[k];
      stage_load[k] = chain;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             up_valid, up_mode, up_parity;
    logic [WIDTH-1:0] up_data;

    if (k == 0) begin : g_head
      assign up_valid  = in_valid;
      assign up_mode   = in_mode;
      assign up_data   = in_data;
      assign up_parity = 1'b0;
    end else begin : g_body
      assign up_valid  = stage_valid[k-1];
      assign up_mode   = stage_mode[k-1];
      assign up_data   = stage_data[k-1];
      assign up_parity = stage_parity[k-1];
    end

    gray_pipe_stage #(
      .STAGE  (k),
      .WIDTH  (WIDTH),
      .STAGES (STAGES)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (stage_load[k]),
      .up_valid  (up_valid),
      .up_mode   (up_mode),
      .up_data   (up_data),
      .up_parity (up_parity),
      .valid     (stage_valid[k]),
      .mode      (stage_mode[k]),
      .data      (stage_data[k]),
      .parity    (stage_parity[k])
    );
  end

  logic unused_parity;
  assign unused_parity = stage_parity[STAGES-1];

  assign in_ready  = stage_load[0];
  assign out_valid = stage_valid[STAGES-1];
  assign out_data  = stage_data[STAGES-1];
  assign out_mode  = stage_mode[STAGES-1];

endmodule

// File: tb/tb_gray_code_pipe.sv
// Self-checking bench for gray_code_pipe: directed, backpressure, reset, round-trip sweeps
// over several WIDTH/STAGES pairs and a long random handshake run against a reference model.
module tb_gray_code_pipe;

  int n_cmp = 0;
  int n_err = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain shift/XOR arithmetic on 64-bit words.
  function automatic logic [63:0] ref_mask(int w);
    return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic [63:0] ref_b2g(logic [63:0] b, int w);
    return (b ^ (b >> 1)) & ref_mask(w);
  endfunction

  function automatic logic [63:0] ref_g2b(logic [63:0] g, int w);
    logic [63:0] r = '0;
    g = g & ref_mask(w);
    for (int k = 0; k < w; k++) r = r ^ (g >> k);
    return r;
  endfunction

  function automatic logic [63:0] ref_conv(logic [63:0] x, logic mode, int w);
    return mode ? ref_g2b(x, w) : ref_b2g(x, w);
  endfunction

  // Main DUT: WIDTH=8, STAGES=2
  logic       in_valid = 1'b0, in_mode = 1'b0, out_ready = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_ready, out_valid, out_mode;
  logic [7:0] out_data;

  gray_code_pipe #(.WIDTH(8), .STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_mode(out_mode)
  );

  // Backpressure DUT: WIDTH=8, STAGES=3
  logic       b_in_valid = 1'b0, b_in_mode = 1'b0, b_out_ready = 1'b1;
  logic [7:0] b_in_data = '0;
  logic       b_in_ready, b_out_valid, b_out_mode;
  logic [7:0] b_out_data;

  gray_code_pipe #(.WIDTH(8), .STAGES(3)) dut_bp (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_mode(b_in_mode), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .out_mode(b_out_mode)
  );

  // Round-trip sweep configurations
  localparam int NCFG = 10;

  function automatic int cfg_w(int g);
    case (g)
      0:       return 1;
      1, 2, 3: return 5;
      4, 5, 6: return 8;
      default: return 13;
    endcase
  endfunction

  function automatic int cfg_s(int g);
    case (g)
      0, 1, 4, 7: return 1;
      2, 5, 8:    return 2;
      3:          return 5;
      6:          return 8;
      default:    return 13;
    endcase
  endfunction

  int rt_go = -1;
  int rt_done = 0;

  for (genvar g = 0; g < NCFG; g++) begin : g_rt
    localparam int W = cfg_w(g);
    localparam int S = cfg_s(g);
    localparam int N = (W > 12) ? 4096 : (1 << W);

    logic         iv = 1'b0, im = 1'b0;
    logic [W-1:0] id = '0;
    logic         ir, ov, om;
    logic [W-1:0] od;

    gray_code_pipe #(.WIDTH(W), .STAGES(S)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .in_data(id), .in_mode(im),
      .out_valid(ov), .out_ready(1'b1), .out_data(od), .out_mode(om)
    );

    initial begin : run
      logic [W-1:0] gq [$];
      logic [63:0]  e;
      int           sent, got;
      wait (rt_go == g);
      for (int p = 0; p < 2; p++) begin
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < N + S + 20 && got < N; cyc++) begin
          @(negedge clk);
          iv = (sent < N);
          im = (p == 1);
          if (sent < N) id = (p == 0) ? W'(sent) : gq[sent];
          #1;
          if (ov) begin
            e = (p == 0) ? ref_b2g(64'(got), W) : 64'(got);
            n_cmp++;
            if (od !== e[W-1:0] || om !== (p == 1)) begin
              n_err++;
              $display("FAIL roundtrip w=%0d s=%0d pass=%0d idx=%0d: got %h/%b want %h/%b",
                       W, S, p, got, od, om, e[W-1:0], (p == 1));
            end
            if (p == 0) begin
              if (got > 0) begin
                n_cmp++;
                if ($countones(od ^ gq[got-1]) != 1) begin
                  n_err++;
                  $display("FAIL gray_step w=%0d s=%0d idx=%0d: got %h after %h want 1-bit change",
                           W, S, got, od, gq[got-1]);
                end
              end
              gq.push_back(od);
            end
            got++;
          end
          if (iv && ir) sent++;
        end
        n_cmp++;
        if (got != N) begin
          n_err++;
          $display("FAIL roundtrip_count w=%0d s=%0d pass=%0d: got %0d want %0d", W, S, p, got, N);
        end
      end
      iv = 1'b0;
      rt_done = rt_done + 1;
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_mode !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_state: got v=%b d=%h m=%b rdy=%b want v=0 d=00 m=0 rdy=1",
               out_valid, out_data, out_mode, in_ready);
    end
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed();
    logic [7:0] din  [4] = '{8'h0A, 8'hFF, 8'h0F, 8'h80};
    logic       dm   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [7:0] dexp [4] = '{8'h0F, 8'h80, 8'h0A, 8'hFF};
    out_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      n_cmp++;
      if (k >= 2 && k < 6) begin
        if (out_valid !== 1'b1 || out_data !== dexp[k-2] || out_mode !== dm[k-2]) begin
          n_err++;
          $display("FAIL directed cyc=%0d: got v=%b d=%h m=%b want v=1 d=%h m=%b",
                   k, out_valid, out_data, out_mode, dexp[k-2], dm[k-2]);
        end
      end else if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL directed_idle cyc=%0d: got v=%b want v=0", k, out_valid);
      end
      in_valid = (k < 4);
      if (k < 4) begin
        in_data = din[k];
        in_mode = dm[k];
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_mixed();
    logic [63:0] qd [$];
    logic        qm [$];
    logic [63:0] e;
    logic        m;
    int          sent = 0, got = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 300 && got < 256; cyc++) begin
      @(negedge clk);
      in_valid = (sent < 256);
      in_data  = 8'(sent);
      in_mode  = sent[0];
      #1;
      if (in_valid) begin
        n_cmp++;
        if (in_ready !== 1'b1) begin
          n_err++;
          $display("FAIL mixed_bubble cyc=%0d: got rdy=%b want 1", cyc, in_ready);
        end
      end
      if (out_valid) begin
        n_cmp++;
        if (qd.size() == 0) begin
          n_err++;
          $display("FAIL mixed_spurious cyc=%0d: got d=%h want no beat", cyc, out_data);
        end else begin
          e = qd.pop_front();
          m = qm.pop_front();
          if (out_data !== e[7:0] || out_mode !== m) begin
            n_err++;
            $display("FAIL mixed idx=%0d: got %h/%b want %h/%b", got, out_data, out_mode, e[7:0], m);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        qd.push_back(ref_conv(64'(in_data), in_mode, 8));
        qm.push_back(in_mode);
        sent++;
      end
    end
    in_valid = 1'b0;
    n_cmp++;
    if (got != 256) begin
      n_err++;
      $display("FAIL mixed_count: got %0d want 256", got);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] bd [10];
    logic       bm [10];
    logic [63:0] e;
    logic [7:0] prev_d = '0;
    logic       prev_m = 1'b0, prev_stall = 1'b0, saw_full = 1'b0, exp_rdy;
    int         sent = 0, got = 0, occ;
    for (int i = 0; i < 10; i++) begin
      bd[i] = 8'($urandom);
      bm[i] = 1'($urandom);
    end
    for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
      @(negedge clk);
      b_in_valid = (sent < 10);
      if (sent < 10) begin
        b_in_data = bd[sent];
        b_in_mode = bm[sent];
      end
      b_out_ready = !(cyc >= 4 && cyc < 9);
      #1;
      occ = sent - got;
      exp_rdy = b_out_ready || (occ < 3);
      if (occ == 3 && !b_out_ready) saw_full = 1'b1;
      n_cmp++;
      if (b_in_ready !== exp_rdy) begin
        n_err++;
        $display("FAIL bp_ready cyc=%0d occ=%0d: got %b want %b", cyc, occ, b_in_ready, exp_rdy);
      end
      if (prev_stall) begin
        n_cmp++;
        if (b_out_valid !== 1'b1 || b_out_data !== prev_d || b_out_mode !== prev_m) begin
          n_err++;
          $display("FAIL bp_hold cyc=%0d: got v=%b d=%h m=%b want v=1 d=%h m=%b",
                   cyc, b_out_valid, b_out_data, b_out_mode, prev_d, prev_m);
        end
      end
      if (b_out_valid && b_out_ready) begin
        n_cmp++;
        if (got >= 10) begin
          n_err++;
          $display("FAIL bp_extra cyc=%0d: got d=%h want no beat", cyc, b_out_data);
        end else begin
          e = ref_conv(64'(bd[got]), bm[got], 8);
          if (b_out_data !== e[7:0] || b_out_mode !== bm[got]) begin
            n_err++;
            $display("FAIL bp_data idx=%0d: got %h/%b want %h/%b",
                     got, b_out_data, b_out_mode, e[7:0], bm[got]);
          end
        end
        got++;
      end
      if (b_in_valid && b_in_ready) sent++;
      prev_stall = b_out_valid && !b_out_ready;
      prev_d = b_out_data;
      prev_m = b_out_mode;
    end
    b_in_valid = 1'b0;
    b_out_ready = 1'b1;
    n_cmp++;
    if (got != 10 || !saw_full) begin
      n_err++;
      $display("FAIL bp_count: got %0d beats full=%b want 10 beats full=1", got, saw_full);
    end
  endtask

  task automatic test_reset_midstream();
    logic stale = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h5A;
    in_mode = 1'b1;
    @(negedge clk);
    in_data = 8'hA5;
    in_mode = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL rst_inflight: got v=%b want 1", out_valid);
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_mode !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid: got v=%b d=%h m=%b rdy=%b want v=0 d=00 m=0 rdy=1",
               out_valid, out_data, out_mode, in_ready);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stale = 1'b1;
    end
    n_cmp++;
    if (stale) begin
      n_err++;
      $display("FAIL rst_stale: got stale beat want none");
    end
  endtask

  task automatic test_roundtrip();
    for (int g = 0; g < NCFG; g++) begin
      rt_go = g;
      wait (rt_done == g + 1);
    end
    rt_go = -1;
  endtask

  task automatic test_random();
    logic [63:0] qd [$];
    logic        qm [$];
    logic [63:0] e;
    logic        m, fired = 1'b0, prev_stall = 1'b0, prev_m = 1'b0;
    logic [7:0]  prev_d = '0;
    int          sent = 0, got = 0;
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 60000 && got < 10000; cyc++) begin
      @(negedge clk);
      if (!in_valid || fired) begin
        in_valid = (sent < 10000) && ($urandom_range(3) != 0);
        in_data  = 8'($urandom);
        in_mode  = 1'($urandom);
      end
      out_ready = ($urandom_range(3) != 0);
      #1;
      if (prev_stall) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== prev_d || out_mode !== prev_m) begin
          n_err++;
          $display("FAIL rand_hold cyc=%0d: got v=%b d=%h m=%b want v=1 d=%h m=%b",
                   cyc, out_valid, out_data, out_mode, prev_d, prev_m);
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (qd.size() == 0) begin
          n_err++;
          $display("FAIL rand_spurious cyc=%0d: got d=%h want no beat", cyc, out_data);
        end else begin
          e = qd.pop_front();
          m = qm.pop_front();
          if (out_data !== e[7:0] || out_mode !== m) begin
            n_err++;
            $display("FAIL rand idx=%0d: got %h/%b want %h/%b", got, out_data, out_mode, e[7:0], m);
          end
        end
        got++;
      end
      fired = in_valid && in_ready;
      if (fired) begin
        qd.push_back(ref_conv(64'(in_data), in_mode, 8));
        qm.push_back(in_mode);
        sent++;
      end
      prev_stall = out_valid && !out_ready;
      prev_d = out_data;
      prev_m = out_mode;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_cmp++;
    if (got != 10000) begin
      n_err++;
      $display("FAIL rand_count: got %0d want 10000", got);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mixed();
    test_backpressure();
    test_reset_midstream();
    test_roundtrip();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gray_code_pipe.md
Name: gray_code_pipe

Overview:
Parametrised, pipelined bidirectional Gray/binary code converter with valid/ready handshake on both sides. Each transaction carries a per-beat mode bit: binary->Gray or Gray->binary. The Gray->binary prefix-XOR chain is split across a configurable number of register stages so wide words close timing. The block sits between counter/encoder logic and CDC pointer paths, replacing the single-width combinational converter.

Parameters:
WIDTH, 8, data width in bits; legal range 1..64.
STAGES, 2, pipeline register stages; legal range 1..WIDTH; fixes latency.

Ports:
clk        input   1      rising-edge clock
rst_n      input   1      synchronous, active-low reset
in_valid   input   1      input beat present
in_ready   output  1      block accepts input beat this cycle
in_data    input   WIDTH  word to convert
in_mode    input   1      0 = binary->Gray, 1 = Gray->binary
out_valid  output  1      output beat present
out_ready  input   1      downstream accepts output beat
out_data   output  WIDTH  converted word
out_mode   output  1      mode the beat was converted with

Behaviour:
- Reset is sampled only on a clk edge with rst_n=0. After that edge: all stage valid bits = 0, out_valid = 0, out_data = 0, out_mode = 0. in_ready = 1 from the first cycle after reset releases.
- Transfer rules:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - in_data and in_mode are captured only on an input transfer.
- Pipeline: STAGES registered stages, each with its own valid bit.
  - Stage k ready = !valid_k | ready_(k+1). The last stage's downstream ready is out_ready.
  - in_ready = stage-1 ready, which is combinational from out_ready through the chain.
  - No bubbles: with out_ready held at 1, throughput is one beat per cycle.
- Latency: an input transferred at edge N is presented on out_valid/out_data after edge N+STAGES-1 (STAGES cycles of registering), provided there is no stall.
- Stall: while out_valid=1 and out_ready=0:
  - out_data and out_mode hold stable.
  - Upstream stages fill until full.
  - in_ready drops to 0 only when every stage is valid.
- Binary->Gray: g = b ^ (b >> 1), computed in stage 1. Later stages pass it through unchanged.
- Gray->binary:
  - Bit recurrence: b[W-1] = g[W-1]; b[i] = b[i+1] ^ g[i].
  - Bits are resolved MSB-first in chunks of C = ceil(WIDTH/STAGES), one chunk per stage.
  - Stage s carries the partially resolved word plus the running MSB-side parity.
  - The final chunk may be shorter than C.
  - Stages beyond the last chunk (possible when C*(STAGES-1) >= WIDTH) pass data through.
- Mode bit travels with its beat. Mixed-mode back-to-back beats are legal and must not interact.
- WIDTH=1: both conversions are identity.
- Reset mid-operation: all in-flight beats are discarded and none are emitted afterwards.
- in_valid may be asserted while in_ready=0. The beat is held by the source and is not captured until in_ready=1.
- out_valid never deasserts without an output transfer or reset.

Decomposition:
- Shared package gray_code_pkg:
  - Constants MODE_B2G = 1'b0 and MODE_G2B = 1'b1.
  - Function chunk_size(width, stages) returning ceil(width/stages).
  - Function chunk_lo(stage, width, stages) returning the lowest bit index resolved in that stage.
- One natural sub-module, gray_pipe_stage:
  - One register slice holding valid, mode, data word and carried parity bit.
  - Parameters: stage index, WIDTH, STAGES.
  - Instantiated STAGES times by a generate loop.
  - The top level contains only the ready chain and the port mapping.

Test Plan:
- WIDTH=8, STAGES=2, out_ready=1: send B2G 0x0A then B2G 0xFF -> out_data 0x0F then 0x80, mode 0, on consecutive cycles, 2 cycles after each input.
- Same config: send G2B 0x0F then G2B 0x80 -> out_data 0x0A then 0xFF, mode 1. Then alternate modes on 0x00..0xFF every cycle -> every result matches the reference model in order.
- Round-trip sweep for WIDTH in {1,5,8,13} and STAGES in {1,2,WIDTH}: B2G of 0..2^W-1 (capped at 4096), fed back as G2B -> each original value returned. B2G outputs of successive inputs differ in exactly 1 bit.
- Backpressure, WIDTH=8, STAGES=3: stream 10 beats, hold out_ready=0 for 5 cycles from cycle 4 ->
  - in_ready falls exactly when 3 beats are buffered.
  - out_data is stable while stalled.
  - All 10 results arrive in order with no loss or duplication.
- Reset mid-stream: drive rst_n=0 for 1 edge with 2 beats in flight -> next cycle out_valid=0, out_data=0, in_ready=1, and no stale beat ever appears.
- Random valid/ready toggling for 10k beats with a scoreboard -> zero mismatches, and out_valid never drops without an output transfer.
